result_capture: RTL and testbench
=================================

RESULT_CAPTURE -- requirements
Module: result_capture

Interface
REQ-001 Parameter WIDTH, default 32, data width of the captured DUT result.
REQ-002 Parameter LATENCY, default 2, DUT pipeline depth in clk cycles (legal 1..16).
REQ-003 Parameter DEPTH, default 16, capture FIFO entries (power of two, 2..256).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 in_valid  input  1  stimulus word presented to the DUT input this cycle.
REQ-007 dut_z  input  WIDTH  DUT result bus, sampled every posedge.
REQ-008 clear  input  1  synchronous flush of tracking pipeline, FIFO and overflow.
REQ-009 out_data  output  WIDTH  head-of-FIFO result (show-ahead).
REQ-010 out_valid  output  1  FIFO non-empty; out_data holds a valid result.
REQ-011 out_ready  input  1  consumer accepts out_data this cycle.
REQ-012 count  output  log2(DEPTH)+1  number of entries held, 0..DEPTH.
REQ-013 overflow  output  1  sticky: at least one result dropped because the FIFO was full.

Function
REQ-014 A LATENCY-stage valid shift register delays in_valid; stage LATENCY output is cap_en.
REQ-015 With cap_en=1 at a posedge, dut_z from that posedge is the result for the in_valid issued LATENCY cycles earlier.
REQ-016 Push: cap_en=1 and (count<DEPTH or pop this cycle) -> dut_z written at the write pointer; write pointer +1.
REQ-017 Pop: out_valid=1 and out_ready=1 -> read pointer +1.
REQ-018 Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 with no gap.
REQ-019 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-020 Full (count=DEPTH) with simultaneous pop and cap_en: push accepted, count stays DEPTH, overflow unchanged.
REQ-021 Full, cap_en=1, no pop: result dropped, FIFO unchanged, overflow set to 1 at that posedge.
REQ-022 overflow stays 1 until reset or clear; it is never cleared by pops.
REQ-023 Empty (count=0): out_valid=0, out_ready ignored, no pointer change; out_data is don't-care.
REQ-024 Empty with cap_en=1: the word is visible on out_data with out_valid=1 the cycle after the push (no same-cycle bypass).
REQ-025 out_data = memory[read pointer] combinationally; it is stable while out_valid=1 and out_ready=0.
REQ-026 clear=1: at that posedge valid pipeline zeroed, pointers and count 0, overflow 0; push and pop in the same cycle are ignored.
REQ-027 in_valid asserted while clear=1 is discarded; the first tracked stimulus is the first in_valid after clear deasserts.
REQ-028 Throughput: one capture and one pop per cycle, sustained indefinitely.

Reset
REQ-029 rst_n=0 immediately, without a clock edge: valid pipeline 0, pointers 0, count 0, out_valid 0, overflow 0.
REQ-030 FIFO storage is not reset; out_data is undefined until the first push.
REQ-031 rst_n deasserted mid-stream: only in_valid sampled after the release is tracked; no pre-reset result ever appears.
REQ-032 Reset release is synchronised by the surrounding design; this block does not add a synchroniser.

Verification
REQ-033 Latency alignment: LATENCY=2, in_valid=1 for 1 cycle at cycle 0 with dut_z=0x00000007 at cycle 2 -> count=1 and out_data=0x00000007 after the cycle-2 posedge.
REQ-034 Gapped stream: in_valid pattern 1,0,1,1 and dut_z driven as 10,99,20,30 -> popped sequence 10,20,30; 99 never captured.
REQ-035 Overflow: DEPTH=16, out_ready=0, 17 consecutive valids -> count=16, overflow=1, popped words are the first 16 in order.
REQ-036 Full with simultaneous push/pop: count=16, out_ready=1, cap_en=1 -> count stays 16, overflow stays 0, new word ends up last.
REQ-037 Wrap: 40 words through DEPTH=16 with out_ready toggled every cycle -> all 40 words returned in order, overflow=0.
REQ-038 Reset and clear mid-stream: rst_n=0 (or clear=1) with count=5 and 2 results in flight -> count=0, out_valid=0, no stale word appears after release.

Source files
------------

// File: rtl/result_capture_if.sv
// Result capture bus: stimulus/result inputs and show-ahead FIFO read port.
// The master drives stimulus and accepts results; the capture block is the slave.
interface result_capture_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 16
) ();
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             in_valid;
   logic [WIDTH-1:0] dut_z;
   logic             clear;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    count;
   logic             overflow;

   modport master (
      output in_valid, dut_z, clear, out_ready,
      input  out_data, out_valid, count, overflow
   );

   modport slave (
      input  in_valid, dut_z, clear, out_ready,
      output out_data, out_valid, count, overflow
   );
endinterface

// File: rtl/result_capture.sv
// Captures DUT results LATENCY cycles after each in_valid into a show-ahead FIFO,
// with a sticky overflow flag for results dropped while the FIFO is full.
module result_capture #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DEPTH   = 16
) (
   input logic             clk,
   input logic             rst_n,
   result_capture_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [LATENCY-1:0] vpipe;
   logic               cap_en;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [CW-1:0]      count_q;
   logic               overflow_q;
   logic               full;
   logic               push;
   logic               pop;
   logic [WIDTH-1:0]   mem [DEPTH];

   assign cap_en = vpipe[LATENCY-1];
   assign full   = (count_q == CW'(DEPTH));

   // Pop frees a slot in the same cycle, so a full FIFO still accepts a capture.
   assign pop  = (count_q != '0) && bus.out_ready && !bus.clear;
   assign push = cap_en && (!full || pop) && !bus.clear;

   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = mem[rd_ptr];
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;

   // Valid tracking pipeline; stage LATENCY-1 lines up with the result on dut_z.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe <= '0;
      end else if (bus.clear) begin
         vpipe <= '0;
      end else begin
         vpipe <= LATENCY'({vpipe, bus.in_valid});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (bus.clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (bus.clear) begin
         count_q <= '0;
      end else begin
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky until reset or clear; pops never release it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (bus.clear) begin
         overflow_q <= 1'b0;
      end else if (cap_en && full && !pop) begin
         overflow_q <= 1'b1;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.dut_z;
   end
endmodule

// File: tb/tb_result_capture.sv
// Self-checking bench for result_capture: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_result_capture;
   localparam int unsigned W  = 32;
   localparam int unsigned L  = 2;
   localparam int unsigned D  = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   result_capture_if #(.WIDTH(W), .DEPTH(D)) bus ();

   result_capture #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: in_valid history (oldest first), FIFO contents, sticky flag.
   bit           mvq[$];
   logic [W-1:0] mfifo[$];
   bit           movf;
   logic [W-1:0] dut_pops[$];

   typedef struct {
      bit           iv;
      logic [W-1:0] z;
      bit           rdy;
      int unsigned  ecnt;
      bit           evld;
      logic [W-1:0] edat;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(bit iv, int unsigned z, bit rdy, int unsigned c, bit v, int unsigned d);
      vec_t r;
      r.iv = iv; r.z = W'(z); r.rdy = rdy; r.ecnt = c; r.evld = v; r.edat = W'(d);
      return r;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mfifo.delete();
      mvq.delete();
      for (int i = 0; i < int'(L); i++) mvq.push_back(1'b0);
      movf = 1'b0;
   endtask

   // One clock: drive at posedge+1, advance model at the edge, check at posedge+1.
   task automatic cycle(input bit iv, input logic [W-1:0] z, input bit clr, input bit rdy);
      bit cap;
      bus.in_valid  = iv;
      bus.dut_z     = z;
      bus.clear     = clr;
      bus.out_ready = rdy;
      if (rst_n && bus.out_valid && rdy && !clr) dut_pops.push_back(bus.out_data);
      @(posedge clk);
      if (!rst_n || clr) begin
         model_reset();
      end else begin
         cap = mvq.pop_front();
         if (mfifo.size() > 0 && rdy) void'(mfifo.pop_front());
         if (cap) begin
            if (mfifo.size() < int'(D)) mfifo.push_back(z);
            else movf = 1'b1;
         end
         mvq.push_back(iv);
      end
      #1;
      chk("count", W'(bus.count), W'(mfifo.size()));
      chk("out_valid", W'(bus.out_valid), W'(mfifo.size() != 0));
      chk("overflow", W'(bus.overflow), W'(movf));
      if (mfifo.size() != 0) chk("out_data", bus.out_data, mfifo[0]);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.dut_z     = '0;
      bus.clear     = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();

      // Asynchronous reset takes effect without a clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("reset_count", W'(bus.count), '0);
      chk("reset_out_valid", W'(bus.out_valid), '0);
      chk("reset_overflow", W'(bus.overflow), '0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Latency alignment, then gapped stream 1,0,1,1 with results 10,99,20,30
      tbl[0]  = mk(1, 0,  0, 0, 0, 0);
      tbl[1]  = mk(0, 0,  0, 0, 0, 0);
      tbl[2]  = mk(0, 7,  0, 1, 1, 7);
      tbl[3]  = mk(0, 5,  1, 0, 0, 0);
      tbl[4]  = mk(1, 0,  0, 0, 0, 0);
      tbl[5]  = mk(0, 0,  0, 0, 0, 0);
      tbl[6]  = mk(1, 10, 0, 1, 1, 10);
      tbl[7]  = mk(1, 99, 0, 1, 1, 10);
      tbl[8]  = mk(0, 20, 0, 2, 1, 10);
      tbl[9]  = mk(0, 30, 0, 3, 1, 10);
      tbl[10] = mk(0, 0,  1, 2, 1, 20);
      tbl[11] = mk(0, 0,  1, 1, 1, 30);
      tbl[12] = mk(0, 0,  1, 0, 0, 0);
      dut_pops.delete();
      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].iv, tbl[i].z, 1'b0, tbl[i].rdy);
         chk($sformatf("tbl%0d_count", i), W'(bus.count), W'(tbl[i].ecnt));
         chk($sformatf("tbl%0d_valid", i), W'(bus.out_valid), W'(tbl[i].evld));
         if (tbl[i].evld) chk($sformatf("tbl%0d_data", i), bus.out_data, tbl[i].edat);
      end
      chk("gap_pop_count", W'(dut_pops.size()), W'(4));
      if (dut_pops.size() == 4) begin
         chk("gap_pop0", dut_pops[0], W'(7));
         chk("gap_pop1", dut_pops[1], W'(10));
         chk("gap_pop2", dut_pops[2], W'(20));
         chk("gap_pop3", dut_pops[3], W'(30));
      end

      // Overflow: 17 valids with no consumer, then drain
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 19; i++) cycle(i < 17, W'(100 + i), 1'b0, 1'b0);
      chk("ovf_count", W'(bus.count), W'(16));
      chk("ovf_flag", W'(bus.overflow), W'(1));
      dut_pops.delete();
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      chk("ovf_drained", W'(dut_pops.size()), W'(16));
      for (int k = 0; k < dut_pops.size(); k++) chk($sformatf("ovf_pop%0d", k), dut_pops[k], W'(102 + k));
      chk("ovf_sticky", W'(bus.overflow), W'(1));

      // Full with simultaneous push and pop
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 19; i++) cycle(i < 17, W'(200 + i), 1'b0, i == 18);
      chk("fullpp_count", W'(bus.count), W'(16));
      chk("fullpp_ovf", W'(bus.overflow), W'(0));
      dut_pops.delete();
      for (int i = 0; i < 16; i++) cycle(1'b0, '0, 1'b0, 1'b1);
      chk("fullpp_drained", W'(dut_pops.size()), W'(16));
      for (int k = 0; k < dut_pops.size(); k++) chk($sformatf("fullpp_pop%0d", k), dut_pops[k], W'(203 + k));

      // Wrap: 40 words through the FIFO with out_ready toggling
      cycle(1'b0, '0, 1'b1, 1'b0);
      dut_pops.delete();
      for (int i = 0; i < 100; i++)
         cycle((i < 80) && (i % 2 == 0), W'(300 + i), 1'b0, (i < 80) ? bit'(i % 2) : 1'b1);
      chk("wrap_pops", W'(dut_pops.size()), W'(40));
      for (int k = 0; k < dut_pops.size(); k++) chk($sformatf("wrap_pop%0d", k), dut_pops[k], W'(302 + 2 * k));
      chk("wrap_ovf", W'(bus.overflow), W'(0));

      // Reset mid-stream: count=5 with two results in flight
      cycle(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) cycle(1'b1, W'(400 + i), 1'b0, 1'b0);
      chk("pre_rst_count", W'(bus.count), W'(5));
      rst_n = 1'b0;
      #2;
      chk("mid_rst_count", W'(bus.count), '0);
      chk("mid_rst_valid", W'(bus.out_valid), '0);
      model_reset();
      cycle(1'b1, W'(450), 1'b0, 1'b1);
      rst_n = 1'b1;
      dut_pops.delete();
      for (int i = 0; i < 5; i++) cycle(1'b0, W'(500 + i), 1'b0, 1'b1);
      chk("post_rst_count", W'(bus.count), '0);
      chk("post_rst_pops", W'(dut_pops.size()), '0);

      // Clear mid-stream: same situation, in_valid during clear is discarded
      for (int i = 0; i < 7; i++) cycle(1'b1, W'(600 + i), 1'b0, 1'b0);
      chk("pre_clr_count", W'(bus.count), W'(5));
      cycle(1'b1, W'(650), 1'b1, 1'b1);
      chk("clr_count", W'(bus.count), '0);
      chk("clr_valid", W'(bus.out_valid), '0);
      dut_pops.delete();
      for (int i = 0; i < 5; i++) cycle(1'b0, W'(700 + i), 1'b0, 1'b1);
      chk("post_clr_count", W'(bus.count), '0);
      chk("post_clr_pops", W'(dut_pops.size()), '0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 199) == 0),
               ($urandom_range(0, 3) < ((i / 500) % 4)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
